// File: rtl/wave_mode_pkg.sv
// Shared types and constants for the waveform-mode selector.
// Default mode encoding and index-width helper.
package wave_mode_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_SAW      = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SINE     = 2'd3
  } wave_mode_e;

  localparam int unsigned NUM_WAVE_MODES = 4;

  // Index width, never below one bit.
  function automatic int unsigned mode_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, counter debounce and
// a registered one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      st    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        st    <= s2;
        cnt   <= '0;
        // Only a rising accepted level counts as a press.
        press <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign key_level = st;

endmodule

// File: rtl/wave_mode_sel.sv
// Waveform-mode selector: debounced next/prev keys step a mode index
// with wrap or saturation; drives binary, one-hot and change strobe.
module wave_mode_sel
  import wave_mode_pkg::*;
#(
  parameter int unsigned NUM_MODES       = NUM_WAVE_MODES,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          WRAP            = 1'b1,
  parameter int unsigned RESET_MODE      = 0,
  localparam int unsigned MW             = mode_width(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_next,
  input  logic                 key_prev,
  output logic [MW-1:0]        mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 mode_changed
);

  localparam logic [NUM_MODES-1:0] RESET_ONEHOT = NUM_MODES'(1) << RESET_MODE;

  logic press_next, press_prev;
  logic next_level, prev_level;
  logic unused_levels;

  logic [MW-1:0]        mode_d;
  logic [NUM_MODES-1:0] onehot_d;
  logic                 changed_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_next),
    .key_level(next_level),
    .press    (press_next)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_prev),
    .key_level(prev_level),
    .press    (press_prev)
  );

  assign unused_levels = next_level ^ prev_level;

  always_comb begin
    mode_d = mode;
    if (32'(mode) >= NUM_MODES) begin
      // Unreachable for legal operation; recover to a known mode.
      mode_d = MW'(RESET_MODE);
    end else if (press_next && !press_prev) begin
      if (32'(mode) == NUM_MODES - 1) mode_d = WRAP ? '0 : mode;
      else                            mode_d = mode + MW'(1);
    end else if (press_prev && !press_next) begin
      if (mode == '0) mode_d = WRAP ? MW'(NUM_MODES - 1) : mode;
      else            mode_d = mode - MW'(1);
    end
    changed_d = (mode_d != mode);
    onehot_d  = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      onehot_d[i] = (mode_d == MW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= MW'(RESET_MODE);
      mode_onehot  <= RESET_ONEHOT;
      mode_changed <= 1'b0;
    end else begin
      mode         <= mode_d;
      mode_onehot  <= onehot_d;
      mode_changed <= changed_d;
    end
  end

endmodule

// File: tb/tb_wave_mode_sel.sv
// Scoreboard bench: three selector variants (wrap, saturate, five modes)
// with expected modes queued at stimulus time and checked on each strobe.
module tb_wave_mode_sel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_next = 0, a_prev = 0, b_next = 0, b_prev = 0, c_next = 0, c_prev = 0;

  logic [1:0] a_mode, b_mode;
  logic [3:0] a_oh, b_oh;
  logic [2:0] c_mode;
  logic [4:0] c_oh;
  logic       a_chg, b_chg, c_chg;

  int n_cmp = 0;
  int n_err = 0;
  int q_a[$];
  int q_b[$];
  int q_c[$];

  always #5 clk = ~clk;

  wave_mode_sel dut_a (
    .clk(clk), .rst(rst), .key_next(a_next), .key_prev(a_prev),
    .mode(a_mode), .mode_onehot(a_oh), .mode_changed(a_chg)
  );

  wave_mode_sel #(.WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_next(b_next), .key_prev(b_prev),
    .mode(b_mode), .mode_onehot(b_oh), .mode_changed(b_chg)
  );

  wave_mode_sel #(.NUM_MODES(5), .RESET_MODE(2)) dut_c (
    .clk(clk), .rst(rst), .key_next(c_next), .key_prev(c_prev),
    .mode(c_mode), .mode_onehot(c_oh), .mode_changed(c_chg)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_key(input int sel, input logic v);
    case (sel)
      0: a_next = v;
      1: a_prev = v;
      2: b_next = v;
      3: b_prev = v;
      4: c_next = v;
      default: c_prev = v;
    endcase
  endtask

  task automatic press(input int sel);
    set_key(sel, 1'b1);
    tick(8);
    set_key(sel, 1'b0);
    tick(10);
  endtask

  // Monitors: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && a_chg) begin
      if (q_a.size() == 0) check("a_unexpected_strobe", int'(a_mode), -1);
      else begin
        int e;
        e = q_a.pop_front();
        check("a_mode", int'(a_mode), e);
        check("a_onehot", int'(a_oh), 1 << e);
      end
    end
    if (!rst && b_chg) begin
      if (q_b.size() == 0) check("b_unexpected_strobe", int'(b_mode), -1);
      else begin
        int e;
        e = q_b.pop_front();
        check("b_mode", int'(b_mode), e);
        check("b_onehot", int'(b_oh), 1 << e);
      end
    end
    if (!rst && c_chg) begin
      if (q_c.size() == 0) check("c_unexpected_strobe", int'(c_mode), -1);
      else begin
        int e;
        e = q_c.pop_front();
        check("c_mode", int'(c_mode), e);
        check("c_onehot", int'(c_oh), 1 << e);
      end
    end
  end

  initial begin
    int bounce[5] = '{1, 0, 1, 1, 0};

    tick(3);
    check("rst_a_mode", int'(a_mode), 0);
    check("rst_a_onehot", int'(a_oh), 4'b0001);
    check("rst_a_changed", int'(a_chg), 0);
    check("rst_c_mode", int'(c_mode), 2);
    check("rst_c_onehot", int'(c_oh), 5'b00100);

    // Key held across reset release: step lands after edge 7.
    rst = 1'b0;
    a_next = 1'b1;
    q_a.push_back(1);
    tick(6);
    check("lat_a_before_edge7", int'(a_mode), 0);
    tick(1);
    check("lat_a_mode_edge7", int'(a_mode), 1);
    check("lat_a_onehot_edge7", int'(a_oh), 4'b0010);
    check("lat_a_changed_edge7", int'(a_chg), 1);
    tick(20);
    check("hold_a_no_repeat", int'(a_mode), 1);
    a_next = 1'b0;
    tick(10);

    // Wrap both directions.
    q_a.push_back(2); press(0);
    q_a.push_back(3); press(0);
    q_a.push_back(0); press(0);
    q_a.push_back(3); press(1);
    check("wrap_a_prev", int'(a_mode), 3);

    // Short pulse rejected, then bouncy press gives exactly one step.
    a_next = 1'b1;
    tick(3);
    a_next = 1'b0;
    tick(10);
    check("glitch_a_rejected", int'(a_mode), 3);
    q_a.push_back(0);
    foreach (bounce[i]) begin
      a_next = bounce[i][0];
      tick(1);
    end
    press(0);
    check("bounce_a_one_step", int'(a_mode), 0);

    // Saturation at both ends.
    press(3);
    check("sat_b_low", int'(b_mode), 0);
    q_b.push_back(1); press(2);
    q_b.push_back(2); press(2);
    q_b.push_back(3); press(2);
    press(2);
    check("sat_b_high", int'(b_mode), 3);

    // Simultaneous next+prev, then five-mode wrap.
    c_next = 1'b1;
    c_prev = 1'b1;
    tick(8);
    c_next = 1'b0;
    c_prev = 1'b0;
    tick(10);
    check("simul_c_hold", int'(c_mode), 2);
    q_c.push_back(3); press(4);
    q_c.push_back(4); press(4);
    q_c.push_back(0); press(4);
    check("wrap_c_end", int'(c_mode), 0);

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    check("q_c_drained", q_c.size(), 0);

    // Asynchronous reset mid-debounce, checked between clock edges.
    q_a.push_back(1); press(0);
    a_next = 1'b1;
    tick(4);
    #1 rst = 1'b1;
    #1;
    check("async_rst_a_mode", int'(a_mode), 0);
    check("async_rst_a_onehot", int'(a_oh), 4'b0001);
    check("async_rst_b_mode", int'(b_mode), 0);
    check("async_rst_c_mode", int'(c_mode), 2);
    check("q_a_final", q_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_mode_sel.md
Name: wave_mode_sel

Overview:
- Parametrised waveform-mode selector for the synthesizer input path.
- Takes two raw push-buttons, next and previous. Each one is synchronised, debounced and edge-detected.
- Steps a mode index over NUM_MODES values, with wrap-around or saturation at the ends.
- Drives binary and one-hot mode outputs plus a change strobe to the oscillator/wave-shaping logic.

Parameters:
- NUM_MODES, 4: number of selectable modes; legal range 2 or more.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a key level change; legal range 1 or more.
- WRAP, 1: 1 = index wraps past the ends; 0 = index saturates at 0 and NUM_MODES-1.
- RESET_MODE, 0: mode index loaded on reset; legal range 0 to NUM_MODES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_next  in  1  raw, asynchronous "next mode" button, active high
- key_prev  in  1  raw, asynchronous "previous mode" button, active high
- mode  out  MW  current mode index, binary; MW = max(1, $clog2(NUM_MODES))
- mode_onehot  out  NUM_MODES  bit[mode] = 1, all other bits 0
- mode_changed  out  1  one-cycle strobe, high in the cycle mode takes a new value

Behaviour:
- Reset: while rst is high, all flops clear asynchronously.
  - mode = RESET_MODE; mode_onehot = 1 << RESET_MODE; mode_changed = 0.
  - Synchroniser flops, debounced levels, debounce counters and press pulses = 0.
  - Deasserting rst mid-press: the held key is seen as a fresh level. After debounce it produces one press.
- Per key, identical pipeline:
  - Two-flop synchroniser s1 -> s2.
  - Debounce, with stable level st and counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
    - If s2 == st: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: st <= s2 and cnt <= 0.
    - Else: cnt <= cnt+1.
  - press is a registered pulse, set in the same edge that st goes 0 to 1. Release (st 1 to 0) produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES cycles on s2 are discarded; cnt resets to 0.
- Mode update on the edge after press:
  - next only: mode+1. At NUM_MODES-1 it becomes 0 if WRAP=1, otherwise it holds.
  - prev only: mode-1. At 0 it becomes NUM_MODES-1 if WRAP=1, otherwise it holds.
  - next and prev pressed in the same cycle: no change.
  - No press: hold.
- mode_changed is registered alongside mode. It is high only if the new value differs from the old one, so a saturated hold or a simultaneous press gives no strobe.
- mode_onehot is registered from the next mode value, so it is always consistent with mode in the same cycle.
- Latency: key_next is high before edge 1 and held. Then s2 = 1 after edge 2, st = 1 and press after edge 2+DEBOUNCE_CYCLES, and mode/mode_changed update after edge 3+DEBOUNCE_CYCLES.
- Holding a key produces exactly one step; there is no auto-repeat.
- Out-of-range mode values (non-power-of-two NUM_MODES) are unreachable. Defensively, any index of NUM_MODES or more loads RESET_MODE on the next edge.

Decomposition:
- Package wave_mode_pkg:
  - Default mode enum: WAVE_SQUARE=0, WAVE_SAW=1, WAVE_TRIANGLE=2, WAVE_SINE=3.
  - Constant NUM_WAVE_MODES=4.
  - Helper function for MW.
- One sub-module, key_debounce, parameter DEBOUNCE_CYCLES.
  - Ports: clk, rst, key_raw, key_level, press.
  - Instantiated twice: next and prev.
- The mode counter, one-hot decode and change strobe stay in wave_mode_sel.

Test Plan:
- Reset with defaults (NUM_MODES=4, DEBOUNCE_CYCLES=4, RESET_MODE=0) -> mode=0, mode_onehot=4'b0001, mode_changed=0. Assert rst mid-count -> mode returns to 0 immediately, without waiting for a clock edge.
- key_next held from before edge 1 -> mode=1, mode_onehot=4'b0010 and a single mode_changed pulse after edge 7. Key kept held 20 more cycles -> no further change.
- Four clean next presses, WRAP=1 -> mode sequence 1,2,3,0. Then one prev press -> 3.
- WRAP=0 at mode=3, next press -> mode stays 3, mode_changed=0. At mode=0, prev press -> stays 0, no strobe.
- key_next high for 3 cycles only (DEBOUNCE_CYCLES=4) -> no change. Bounce pattern 1,0,1,1,0 then solid 1 -> exactly one step.
- NUM_MODES=5, RESET_MODE=2: next and prev debounced into the same cycle -> mode stays 2, no strobe. Three next presses -> 3,4,0.
